// File: rtl/debouncer_n_pkg.sv
// Shared constants and types for the N-channel input conditioner.
//   PS2_STABLE_CYCLES : default stability window for PS/2 at the divided clock
//   IDLE_LEVEL        : idle level of PS/2 and UART lines
//   PS2_CLK..SERIAL_IN: board channel indices
//   chan_out_t        : per-channel registered result (level + edge strobes)
package debouncer_n_pkg;

  localparam int   PS2_STABLE_CYCLES = 16;
  localparam logic IDLE_LEVEL        = 1'b1;

  localparam int PS2_CLK   = 0;
  localparam int PS2_DATA  = 1;
  localparam int BTN       = 2;
  localparam int SERIAL_IN = 3;

  typedef struct packed {
    logic lvl;
    logic rise;
    logic fall;
  } chan_out_t;

endpackage

// File: rtl/debounce_channel.sv
// Single-bit input conditioner: synchroniser, stability counter, edge strobes.
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   in_i   : raw asynchronous input
//   q_o    : registered level plus one-cycle rise/fall strobes
// With BYPASS=1 the counter is skipped and the level follows the synchroniser.
module debounce_channel
  import debouncer_n_pkg::*;
#(
  parameter int   SYNC_STAGES   = 2,
  parameter int   STABLE_CYCLES = PS2_STABLE_CYCLES,
  parameter logic RESET_VAL     = IDLE_LEVEL,
  parameter logic BYPASS        = 1'b0
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      in_i,
  output chan_out_t q_o
);

  localparam int            CW      = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   out_q, out_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    out_d = out_q;
    cnt_d = '0;
    if (BYPASS) begin
      out_d = s;
    end else if (s != out_q) begin
      // The update cycle reloads the counter to 0, so it never wraps.
      if (cnt_q == CNT_MAX) out_d = s;
      else                  cnt_d = cnt_q + 1'b1;
    end
    rise_d =  out_d & ~out_q;
    fall_d = ~out_d &  out_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      cnt_q  <= '0;
      out_q  <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign q_o = '{lvl: out_q, rise: rise_q, fall: fall_q};

endmodule

// File: rtl/debouncer_n.sv
// N-channel input conditioner between raw board pins and the SoC.
//   clk     : system clock, single domain
//   reset   : asynchronous active-low reset
//   in      : raw asynchronous inputs, one per channel
//   out     : debounced (or synchronised-only) levels
//   rise    : one-cycle pulse per channel on 0->1 of out
//   fall    : one-cycle pulse per channel on 1->0 of out
//   changed : OR of all strobes, same cycle as the strobes
module debouncer_n
  import debouncer_n_pkg::*;
#(
  parameter int                  CHANNELS      = 2,
  parameter int                  SYNC_STAGES   = 2,
  parameter int                  STABLE_CYCLES = PS2_STABLE_CYCLES,
  parameter logic [CHANNELS-1:0] RESET_VALUE   = {CHANNELS{IDLE_LEVEL}},
  parameter logic [CHANNELS-1:0] BYPASS_MASK   = {CHANNELS{1'b0}}
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] in,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                changed
);

  chan_out_t ch_q [CHANNELS];

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES),
      .RESET_VAL    (RESET_VALUE[gi]),
      .BYPASS       (BYPASS_MASK[gi])
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .in_i (in[gi]),
      .q_o  (ch_q[gi])
    );
    assign out[gi]  = ch_q[gi].lvl;
    assign rise[gi] = ch_q[gi].rise;
    assign fall[gi] = ch_q[gi].fall;
  end

  // Pure OR of registered strobes, so it is glitch-free and aligned with them.
  assign changed = |(rise | fall);

endmodule

// File: tb/tb_debouncer_n.sv
module tb_debouncer_n;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] in;
  logic [1:0] out, rise, fall;
  logic       changed;

  always #5 clk = ~clk;

  debouncer_n #(
    .CHANNELS(2), .SYNC_STAGES(2), .STABLE_CYCLES(4),
    .RESET_VALUE(2'b11), .BYPASS_MASK(2'b10)
  ) dut (
    .clk(clk), .reset(reset), .in(in),
    .out(out), .rise(rise), .fall(fall), .changed(changed)
  );

  typedef struct {
    logic       rst_n;
    logic [1:0] in;
    logic [1:0] out;
    logic [1:0] rise;
    logic [1:0] fall;
    logic       chg;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(int n, logic r, logic [1:0] i, logic [1:0] o,
                     logic [1:0] ri, logic [1:0] fa, logic c);
    vec_t v;
    v.rst_n = r; v.in = i; v.out = o; v.rise = ri; v.fall = fa; v.chg = c;
    for (int k = 0; k < n; k++) vecs.push_back(v);
  endtask

  task automatic cmp(string nm, int k, logic [1:0] a, logic [1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s vec %0d: got %b expected %b", nm, k, a, e);
    end
  endtask

  // ch0 (debounced) fall then rise, ch1 held high; edge 6 after input change.
  task automatic fall0_rise0();
    add(5, 1, 2'b10, 2'b11, 2'b00, 2'b00, 0);
    add(1, 1, 2'b10, 2'b10, 2'b00, 2'b01, 1);
    add(4, 1, 2'b10, 2'b10, 2'b00, 2'b00, 0);
    add(5, 1, 2'b11, 2'b10, 2'b00, 2'b00, 0);
    add(1, 1, 2'b11, 2'b11, 2'b01, 2'b00, 1);
    add(4, 1, 2'b11, 2'b11, 2'b00, 2'b00, 0);
  endtask

  initial begin
    vec_t e;
    reset = 1'b0;
    in    = 2'b00;

    // Reset with inputs low: outputs held at reset value, no strobes.
    add(3, 0, 2'b00, 2'b11, 2'b00, 2'b00, 0);
    // Release with inputs idle-high: quiet for 20 cycles.
    add(20, 1, 2'b11, 2'b11, 2'b00, 2'b00, 0);
    // Clean fall/rise on ch0.
    fall0_rise0();
    // 3-cycle glitch on ch0 is rejected.
    add(3, 1, 2'b10, 2'b11, 2'b00, 2'b00, 0);
    add(10, 1, 2'b11, 2'b11, 2'b00, 2'b00, 0);
    // Then a long low is accepted with the usual timing.
    fall0_rise0();
    // Bypass ch1 fall at edge 3.
    add(2, 1, 2'b01, 2'b11, 2'b00, 2'b00, 0);
    add(1, 1, 2'b01, 2'b01, 2'b00, 2'b10, 1);
    add(3, 1, 2'b01, 2'b01, 2'b00, 2'b00, 0);
    // Bypass ch1 rise at edge 3.
    add(2, 1, 2'b11, 2'b01, 2'b00, 2'b00, 0);
    add(1, 1, 2'b11, 2'b11, 2'b10, 2'b00, 1);
    add(3, 1, 2'b11, 2'b11, 2'b00, 2'b00, 0);
    // 1-cycle low glitch on ch1 passes as fall then rise.
    add(1, 1, 2'b01, 2'b11, 2'b00, 2'b00, 0);
    add(1, 1, 2'b11, 2'b11, 2'b00, 2'b00, 0);
    add(1, 1, 2'b11, 2'b01, 2'b00, 2'b10, 1);
    add(1, 1, 2'b11, 2'b11, 2'b10, 2'b00, 1);
    add(3, 1, 2'b11, 2'b11, 2'b00, 2'b00, 0);
    // Drive both low: ch1 falls at edge 3, ch0 at edge 6.
    add(2, 1, 2'b00, 2'b11, 2'b00, 2'b00, 0);
    add(1, 1, 2'b00, 2'b01, 2'b00, 2'b10, 1);
    add(2, 1, 2'b00, 2'b01, 2'b00, 2'b00, 0);
    add(1, 1, 2'b00, 2'b00, 2'b00, 2'b01, 1);
    add(3, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
    // Simultaneous rise: rise[1] at edge 3, rise[0] at edge 6.
    add(2, 1, 2'b11, 2'b00, 2'b00, 2'b00, 0);
    add(1, 1, 2'b11, 2'b10, 2'b10, 2'b00, 1);
    add(2, 1, 2'b11, 2'b10, 2'b00, 2'b00, 0);
    add(1, 1, 2'b11, 2'b11, 2'b01, 2'b00, 1);
    add(3, 1, 2'b11, 2'b11, 2'b00, 2'b00, 0);
    // Mid-count reset: ch0 counter reaches 2, then a 1-cycle reset.
    add(4, 1, 2'b10, 2'b11, 2'b00, 2'b00, 0);
    add(1, 0, 2'b10, 2'b11, 2'b00, 2'b00, 0);
    // Full window restarts from release: fall[0] at edge 6.
    add(5, 1, 2'b10, 2'b11, 2'b00, 2'b00, 0);
    add(1, 1, 2'b10, 2'b10, 2'b00, 2'b01, 1);
    add(3, 1, 2'b10, 2'b10, 2'b00, 2'b00, 0);

    foreach (vecs[k]) begin
      @(negedge clk);
      reset = vecs[k].rst_n;
      in    = vecs[k].in;
      sb.push_back(vecs[k]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      cmp("out",  k, out,  e.out);
      cmp("rise", k, rise, e.rise);
      cmp("fall", k, fall, e.fall);
      cmp("changed", k, {1'b0, changed}, {1'b0, e.chg});
      cmp("rise_and_fall", k, rise & fall, 2'b00);
    end

    // Asynchronous reset between edges restores out without a clock.
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    cmp("async_out",  -1, out, 2'b11);
    cmp("async_fall", -1, fall, 2'b00);
    cmp("async_chg",  -1, {1'b0, changed}, 2'b00);
    @(negedge clk);
    reset = 1'b1;
    in    = 2'b11;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      cmp("post_rel_out",  c, out, 2'b11);
      cmp("post_rel_edge", c, rise | fall, 2'b00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
